ahb_master_arbiter: RTL

Two-master AHB-Lite arbiter that merges the Zscale instruction port (imem, master 0) and data port (dmem, master 1) onto a single AHB-Lite slave port. It sits between ExampleTopZscale and a single-ported memory or interconnect. Each master's accepted address phase is buffered. Masters are granted round-robin, and the slave response is routed back to the owning master.

---
 rtl/ahb_master_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: buffers each master's address phase, grants round-robin,
// and routes the single slave port's response back to the owning master.
module ahb_master_arbiter #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          resetn,
  // master 0 (imem)
  input  logic [1:0]    m0_htrans,
  input  logic [AW-1:0] m0_haddr,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [2:0]    m0_hburst,
  input  logic [3:0]    m0_hprot,
  input  logic          m0_hmastlock,
  input  logic [DW-1:0] m0_hwdata,
  output logic [DW-1:0] m0_hrdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  // master 1 (dmem)
  input  logic [1:0]    m1_htrans,
  input  logic [AW-1:0] m1_haddr,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [2:0]    m1_hburst,
  input  logic [3:0]    m1_hprot,
  input  logic          m1_hmastlock,
  input  logic [DW-1:0] m1_hwdata,
  output logic [DW-1:0] m1_hrdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  // slave port
  output logic [1:0]    s_htrans,
  output logic [AW-1:0] s_haddr,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [2:0]    s_hburst,
  output logic [3:0]    s_hprot,
  output logic          s_hmastlock,
  output logic [DW-1:0] s_hwdata,
  input  logic [DW-1:0] s_hrdata,
  input  logic          s_hready,
  input  logic          s_hresp
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
    logic          lock;
  } ctrl_t;

  typedef enum logic [1:0] {MstFree, MstPend, MstOwn} mst_e;
  typedef enum logic [1:0] {StIdle, StAddr, StData} slv_e;

  logic [1:0] htrans [2];
  ctrl_t      live   [2];
  ctrl_t      buf_q  [2];
  ctrl_t      cand   [2];
  mst_e       mst_q  [2];
  logic [1:0] in_data, hready, hresp, acc, req;

  slv_e       slv_q;
  logic       owner_q, last_q;
  ctrl_t      s_ctrl_q;
  logic [1:0] s_htrans_q;
  logic       can_grant, grant, win;

  // BUSY is handled as IDLE and SEQ as NONSEQ, so only htrans[1] matters.
  logic unused_htrans_lsb;
  assign unused_htrans_lsb = ^{m0_htrans[0], m1_htrans[0]};

  assign htrans[0] = m0_htrans;
  assign htrans[1] = m1_htrans;
  assign live[0]   = {m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock};
  assign live[1]   = {m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_data[i] = (slv_q == StData) && (mst_q[i] == MstOwn) && (owner_q == 1'(i));
      hready[i]  = (mst_q[i] == MstFree) || (in_data[i] && s_hready);
      hresp[i]   = in_data[i] && s_hresp;
      acc[i]     = hready[i] && htrans[i][1];
      // A request accepted this cycle is eligible for grant at the same edge.
      req[i]     = (mst_q[i] == MstPend) || acc[i];
      cand[i]    = acc[i] ? live[i] : buf_q[i];
    end
    can_grant = (slv_q == StIdle) || ((slv_q == StData) && s_hready);
    grant     = can_grant && (req[0] || req[1]);
    win       = (req[0] && req[1]) ? ~last_q : req[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        mst_q[i] <= MstFree;
        buf_q[i] <= '0;
      end
      slv_q      <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      s_ctrl_q   <= '0;
      s_htrans_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) buf_q[i] <= live[i];
        if (grant && (win == 1'(i))) begin
          mst_q[i] <= MstOwn;
        end else if (acc[i]) begin
          mst_q[i] <= MstPend;
        end else if (in_data[i] && s_hready) begin
          mst_q[i] <= MstFree;
        end
      end

      unique case (slv_q)
        StIdle: begin
          if (grant) begin
            slv_q      <= StAddr;
            s_htrans_q <= 2'b10;
          end
        end
        StAddr: begin
          if (s_hready) begin
            slv_q      <= StData;
            s_htrans_q <= 2'b00;
          end
        end
        StData: begin
          // Back-to-back grant in the completion cycle avoids an idle bubble.
          if (s_hready) begin
            slv_q      <= grant ? StAddr : StIdle;
            s_htrans_q <= grant ? 2'b10 : 2'b00;
          end
        end
        default: begin
          slv_q      <= StIdle;
          s_htrans_q <= 2'b00;
        end
      endcase

      if (grant) begin
        owner_q  <= win;
        last_q   <= win;
        s_ctrl_q <= cand[win];
      end
    end
  end

  assign s_htrans    = s_htrans_q;
  assign s_haddr     = s_ctrl_q.addr;
  assign s_hwrite    = s_ctrl_q.write;
  assign s_hsize     = s_ctrl_q.size;
  assign s_hburst    = s_ctrl_q.burst;
  assign s_hprot     = s_ctrl_q.prot;
  assign s_hmastlock = s_ctrl_q.lock;
  assign s_hwdata    = owner_q ? m1_hwdata : m0_hwdata;

  assign m0_hready = hready[0];
  assign m1_hready = hready[1];
  assign m0_hresp  = hresp[0];
  assign m1_hresp  = hresp[1];
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

endmodule
